// File: rtl/dispatch_pair_buffer_pkg.sv
// rtl/dispatch_pair_buffer_pkg.sv - shared uop types and helpers for the dispatch pair buffer
package dispatch_pair_buffer_pkg;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MDU  = 2'd2,
    FU_LSU  = 2'd3
  } FUType;

  localparam int FUNC_ALU_ENQ_WIDTH = 2;

  typedef struct packed {
    logic        valid;
    FUType       fuType;
    logic [6:0]  rob_idx;
    logic [31:0] imm;
  } UOPBundle;

  typedef enum logic [1:0] {
    DPB_EMPTY = 2'd0,
    DPB_BOTH  = 2'd1,
    DPB_ONE   = 2'd2
  } dpb_state_e;

  // A uop with no functional unit never waits on a queue.
  function automatic logic has_slot(input FUType fu, input logic [1:0] alu_free,
                                    input logic mdu_ready, input logic lsu_ready);
    logic ok;
    case (fu)
      FU_ALU:  ok = (alu_free != 2'd0);
      FU_MDU:  ok = mdu_ready;
      FU_LSU:  ok = lsu_ready;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dispatch_pair_buffer_steer.sv
// rtl/dispatch_pair_buffer_steer.sv - combinational in-order dispatch decision and queue routing
module dispatch_pair_buffer_steer
  import dispatch_pair_buffer_pkg::*;
(
  input  logic                          pend0,
  input  logic                          pend1,
  input  FUType                         fu0,
  input  FUType                         fu1,
  input  logic [1:0]                    alu_free,
  input  logic                          mdu_ready,
  input  logic                          lsu_ready,
  output logic                          d0,
  output logic                          d1,
  output logic [FUNC_ALU_ENQ_WIDTH-1:0] alu_enq,
  output logic                          alu_slot0_sel,
  output logic                          mdu_enq,
  output logic                          mdu_sel,
  output logic                          lsu_enq,
  output logic                          lsu_sel
);

  logic cap1;
  logic d0_alu, d1_alu, d0_mdu, d1_mdu, d0_lsu, d1_lsu;

  always_comb begin
    cap1 = 1'b0;
    d0   = pend0 && has_slot(fu0, alu_free, mdu_ready, lsu_ready);
    if (!pend0) begin
      cap1 = has_slot(fu1, alu_free, mdu_ready, lsu_ready);
    end else if (fu1 == FU_NONE) begin
      cap1 = 1'b1;
    end else if (fu0 == fu1) begin
      // Shared queue: only the ALU can take two in one cycle.
      cap1 = (fu1 == FU_ALU) && (alu_free == 2'd2);
    end else begin
      cap1 = has_slot(fu1, alu_free, mdu_ready, lsu_ready);
    end
    d1 = pend1 && (!pend0 || d0) && cap1;
  end

  always_comb begin
    d0_alu = d0 && (fu0 == FU_ALU);
    d1_alu = d1 && (fu1 == FU_ALU);
    d0_mdu = d0 && (fu0 == FU_MDU);
    d1_mdu = d1 && (fu1 == FU_MDU);
    d0_lsu = d0 && (fu0 == FU_LSU);
    d1_lsu = d1 && (fu1 == FU_LSU);

    alu_enq       = '0;
    alu_enq[0]    = d0_alu || d1_alu;
    alu_enq[1]    = d0_alu && d1_alu;
    alu_slot0_sel = !d0_alu;
    mdu_enq       = d0_mdu || d1_mdu;
    mdu_sel       = !d0_mdu;
    lsu_enq       = d0_lsu || d1_lsu;
    lsu_sel       = !d0_lsu;
  end

endmodule

// File: rtl/dispatch_pair_buffer.sv
// rtl/dispatch_pair_buffer.sv - rename-to-dispatch pair register with per-queue steering and hold
module dispatch_pair_buffer
  import dispatch_pair_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  UOPBundle   inst0_in,
  input  UOPBundle   inst1_in,
  output logic       in_ready,
  input  logic [1:0] alu_free,
  input  logic       mdu_ready,
  input  logic       lsu_ready,
  output logic       alu_enq0,
  output logic       alu_enq1,
  output UOPBundle   alu_uop0,
  output UOPBundle   alu_uop1,
  output logic       mdu_enq,
  output UOPBundle   mdu_uop,
  output logic       lsu_enq,
  output UOPBundle   lsu_uop
);

  UOPBundle   hold0, hold1;
  logic       pend0, pend1;
  dpb_state_e state;

  logic                          d0, d1, done, kill, capture;
  logic [FUNC_ALU_ENQ_WIDTH-1:0] s_alu_enq;
  logic                          s_alu_sel, s_mdu_enq, s_mdu_sel, s_lsu_enq, s_lsu_sel;

  always_comb begin
    if (pend0)      state = DPB_BOTH;
    else if (pend1) state = DPB_ONE;
    else            state = DPB_EMPTY;
  end

  dispatch_pair_buffer_steer u_steer (
    .pend0         (pend0),
    .pend1         (pend1),
    .fu0           (hold0.fuType),
    .fu1           (hold1.fuType),
    .alu_free      (alu_free),
    .mdu_ready     (mdu_ready),
    .lsu_ready     (lsu_ready),
    .d0            (d0),
    .d1            (d1),
    .alu_enq       (s_alu_enq),
    .alu_slot0_sel (s_alu_sel),
    .mdu_enq       (s_mdu_enq),
    .mdu_sel       (s_mdu_sel),
    .lsu_enq       (s_lsu_enq),
    .lsu_sel       (s_lsu_sel)
  );

  // Reset behaves like a flush for everything visible in its own cycle.
  assign kill     = flush || rst;
  assign done     = (!pend0 || d0) && (!pend1 || d1);
  assign in_ready = ((state == DPB_EMPTY) || done) && !kill;
  assign capture  = in_ready && (inst0_in.valid || inst1_in.valid);

  always_comb begin
    alu_enq0 = s_alu_enq[0] && !kill;
    alu_enq1 = s_alu_enq[1] && !kill;
    mdu_enq  = s_mdu_enq && !kill;
    lsu_enq  = s_lsu_enq && !kill;
    alu_uop0 = '0;
    alu_uop1 = '0;
    mdu_uop  = '0;
    lsu_uop  = '0;
    if (alu_enq0) alu_uop0 = s_alu_sel ? hold1 : hold0;
    if (alu_enq1) alu_uop1 = hold1;
    if (mdu_enq)  mdu_uop  = s_mdu_sel ? hold1 : hold0;
    if (lsu_enq)  lsu_uop  = s_lsu_sel ? hold1 : hold0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else if (flush) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else if (capture) begin
      hold0 <= inst0_in;
      hold1 <= inst1_in;
      pend0 <= inst0_in.valid;
      pend1 <= inst1_in.valid;
    end else begin
      pend0 <= pend0 && !d0;
      pend1 <= pend1 && !d1;
    end
  end

endmodule

// File: tb/tb_dispatch_pair_buffer.sv
// tb/tb_dispatch_pair_buffer.sv - directed vector table plus randomized run against an in-order queue model
module tb_dispatch_pair_buffer;
  import dispatch_pair_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush;
  UOPBundle   inst0_in, inst1_in;
  logic       in_ready;
  logic [1:0] alu_free;
  logic       mdu_ready, lsu_ready;
  logic       alu_enq0, alu_enq1, mdu_enq, lsu_enq;
  UOPBundle   alu_uop0, alu_uop1, mdu_uop, lsu_uop;

  int checks = 0;
  int failures = 0;

  UOPBundle mq[$];

  always #5 clk = ~clk;

  dispatch_pair_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst0_in(inst0_in), .inst1_in(inst1_in), .in_ready(in_ready),
    .alu_free(alu_free), .mdu_ready(mdu_ready), .lsu_ready(lsu_ready),
    .alu_enq0(alu_enq0), .alu_enq1(alu_enq1), .alu_uop0(alu_uop0), .alu_uop1(alu_uop1),
    .mdu_enq(mdu_enq), .mdu_uop(mdu_uop), .lsu_enq(lsu_enq), .lsu_uop(lsu_uop)
  );

  typedef struct {
    logic       r, f, v0;
    FUType      f0;
    logic       v1;
    FUType      f1;
    logic [1:0] af;
    logic       mr, lr;
    logic [4:0] exp;  // {alu_enq0, alu_enq1, mdu_enq, lsu_enq, in_ready}
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic v0, input FUType f0,
                              input logic v1, input FUType f1, input logic [1:0] af,
                              input logic mr, input logic lr, input logic [4:0] exp);
    vec_t v;
    v.r = r; v.f = f; v.v0 = v0; v.f0 = f0; v.v1 = v1; v.f1 = f1;
    v.af = af; v.mr = mr; v.lr = lr; v.exp = exp;
    return v;
  endfunction

  function automatic UOPBundle mkuop(input logic v, input FUType fu, input logic [6:0] idx);
    UOPBundle u;
    u.valid = v; u.fuType = fu; u.rob_idx = idx; u.imm = $urandom;
    return u;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One cycle: drive, compare against the in-order model (and table constants if given), clock, update model.
  task automatic step(input logic r, input logic f, input UOPBundle i0, input UOPBundle i1,
                      input logic [1:0] af, input logic mr, input logic lr,
                      input bit has_exp, input logic [4:0] exp, input string nm);
    int acap, n;
    bit mcap, lcap, ok, e_rdy;
    logic e_a0, e_a1, e_m, e_l;
    UOPBundle e_au0, e_au1, e_mu, e_lu;
    @(negedge clk);
    rst = r; flush = f; inst0_in = i0; inst1_in = i1;
    alu_free = af; mdu_ready = mr; lsu_ready = lr;
    #1;
    e_a0 = 0; e_a1 = 0; e_m = 0; e_l = 0;
    e_au0 = '0; e_au1 = '0; e_mu = '0; e_lu = '0;
    acap = int'(af); mcap = mr; lcap = lr; n = 0;
    if (!(r || f)) begin
      for (int i = 0; i < mq.size(); i++) begin
        case (mq[i].fuType)
          FU_ALU:  ok = (acap > 0);
          FU_MDU:  ok = mcap;
          FU_LSU:  ok = lcap;
          default: ok = 1;
        endcase
        if (!ok) break;
        case (mq[i].fuType)
          FU_ALU: begin
            acap--;
            if (!e_a0) begin e_a0 = 1; e_au0 = mq[i]; end
            else begin e_a1 = 1; e_au1 = mq[i]; end
          end
          FU_MDU: begin mcap = 0; e_m = 1; e_mu = mq[i]; end
          FU_LSU: begin lcap = 0; e_l = 1; e_lu = mq[i]; end
          default: ;
        endcase
        n++;
      end
    end
    e_rdy = (n == mq.size()) && !r && !f;

    chk({nm, "_m_alu_enq0"}, 64'(alu_enq0), 64'(e_a0));
    chk({nm, "_m_alu_enq1"}, 64'(alu_enq1), 64'(e_a1));
    chk({nm, "_m_mdu_enq"},  64'(mdu_enq),  64'(e_m));
    chk({nm, "_m_lsu_enq"},  64'(lsu_enq),  64'(e_l));
    chk({nm, "_m_in_ready"}, 64'(in_ready), 64'(e_rdy));
    chk({nm, "_m_alu_uop0"}, 64'(alu_uop0), 64'(e_au0));
    chk({nm, "_m_alu_uop1"}, 64'(alu_uop1), 64'(e_au1));
    chk({nm, "_m_mdu_uop"},  64'(mdu_uop),  64'(e_mu));
    chk({nm, "_m_lsu_uop"},  64'(lsu_uop),  64'(e_lu));
    if (has_exp)
      chk({nm, "_tbl_strobes"}, 64'({alu_enq0, alu_enq1, mdu_enq, lsu_enq, in_ready}), 64'(exp));

    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else if (e_rdy && (i0.valid || i1.valid)) begin
      mq.delete();
      if (i0.valid) mq.push_back(i0);
      if (i1.valid) mq.push_back(i1);
    end else begin
      repeat (n) void'(mq.pop_front());
    end
  endtask

  vec_t tv[26];

  initial begin
    UOPBundle u0, u1;
    rst = 1; flush = 0; inst0_in = '0; inst1_in = '0;
    alu_free = 2; mdu_ready = 1; lsu_ready = 1;

    tv[0]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00001);
    tv[1]  = mk(0,0, 1,FU_ALU,  1,FU_LSU,  2,1,1, 5'b00001);
    tv[2]  = mk(0,0, 1,FU_ALU,  1,FU_MDU,  2,1,1, 5'b10011);
    tv[3]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b10101);
    tv[4]  = mk(0,0, 1,FU_ALU,  1,FU_ALU,  1,1,1, 5'b00001);
    tv[5]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 1,1,1, 5'b10000);
    tv[6]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b10001);
    tv[7]  = mk(0,0, 1,FU_MDU,  1,FU_MDU,  2,1,1, 5'b00001);
    tv[8]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00100);
    tv[9]  = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00101);
    tv[10] = mk(0,0, 1,FU_LSU,  1,FU_ALU,  2,1,0, 5'b00001);
    tv[11] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,0, 5'b00000);
    tv[12] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,0, 5'b00000);
    tv[13] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,0, 5'b00000);
    tv[14] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b10011);
    tv[15] = mk(0,0, 1,FU_ALU,  1,FU_ALU,  1,1,1, 5'b00001);
    tv[16] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 1,1,1, 5'b10000);
    tv[17] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 0,1,1, 5'b00000);
    tv[18] = mk(0,1, 1,FU_ALU,  1,FU_LSU,  2,1,1, 5'b00000);
    tv[19] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00001);
    tv[20] = mk(0,0, 0,FU_NONE, 1,FU_NONE, 2,1,1, 5'b00001);
    tv[21] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00001);
    tv[22] = mk(0,0, 1,FU_MDU,  1,FU_ALU,  2,0,1, 5'b00001);
    tv[23] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,0,1, 5'b00000);
    tv[24] = mk(1,0, 0,FU_NONE, 0,FU_NONE, 2,0,1, 5'b00000);
    tv[25] = mk(0,0, 0,FU_NONE, 0,FU_NONE, 2,1,1, 5'b00001);

    u0 = '0; u1 = '0;
    step(1, 0, u0, u1, 2, 1, 1, 0, 5'b0, "rst_a");
    step(1, 0, u0, u1, 2, 1, 1, 0, 5'b0, "rst_b");

    for (int i = 0; i < 26; i++) begin
      u0 = mkuop(tv[i].v0, tv[i].f0, 7'(2 * i));
      u1 = mkuop(tv[i].v1, tv[i].f1, 7'(2 * i + 1));
      step(tv[i].r, tv[i].f, u0, u1, tv[i].af, tv[i].mr, tv[i].lr, 1, tv[i].exp,
           $sformatf("v%0d", i));
    end

    for (int i = 0; i < 600; i++) begin
      u0 = mkuop(1'($urandom), FUType'($urandom_range(0, 3)), 7'($urandom));
      u1 = mkuop(1'($urandom), FUType'($urandom_range(0, 3)), 7'($urandom));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), u0, u1,
           2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 0, 5'b0,
           $sformatf("r%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
